// File: rtl/display_pkg.sv
// Shared types, default timing constants and the leading-zero helper for the
// seven-segment scan path.
package display_pkg;

  // Scan phase: all digits dark (guard) or one digit lit (show).
  typedef enum logic [0:0] {
    S_GUARD = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_e;

  localparam int DEF_REFRESH_DIV  = 50000;
  localparam int DEF_GUARD_CYCLES = 16;
  localparam int MAX_DIGITS       = 8;

  // Bit i is set when digit i is a leading zero that may be blanked: i > 0,
  // i < n, and every nibble from i up to n-1 is zero. Digit 0 is never set.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      n
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_run;
    mask     = {MAX_DIGITS{1'b0}};
    zero_run = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < n) begin
        zero_run = zero_run & (value[4*i +: 4] == 4'h0);
        mask[i]  = zero_run;
      end else begin
        mask[i] = 1'b0;
      end
    end
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a multi-digit seven-segment display. A shadow
// register takes loads at any time; the displayed (active) value only changes
// at the frame boundary so a digit sweep never mixes two values.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);

  localparam int LEN_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int PW      = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] SHOW_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  scan_state_e             state_r;
  logic [DW-1:0]           digit_r;
  logic [PW-1:0]           presc_r;
  logic [4*NUM_DIGITS-1:0] shadow_r;
  logic [4*NUM_DIGITS-1:0] active_r;
  logic                    pending_r;

  scan_state_e             state_next_s;
  logic [DW-1:0]           digit_next_s;
  logic [PW-1:0]           presc_next_s;
  logic                    commit_s;
  logic [4*NUM_DIGITS-1:0] active_next_s;
  logic [4*NUM_DIGITS-1:0] shadow_next_s;
  logic                    pending_next_s;
  logic [4*MAX_DIGITS-1:0] active_pad_s;
  logic [MAX_DIGITS-1:0]   lz_full_s;
  logic [2:0]              digit_ext_s;
  logic                    suppress_s;
  logic [3:0]              nibble_next_s;
  logic [NUM_DIGITS-1:0]   en_next_s;
  logic                    frame_done_next_s;

  // Scan sequencing: guard/show phase, prescaler and digit walk.
  always_comb begin
    state_next_s = state_r;
    digit_next_s = digit_r;
    presc_next_s = presc_r + PW'(1);
    commit_s     = 1'b0;
    case (state_r)
      S_GUARD: begin
        if (presc_r == GUARD_LAST) begin
          state_next_s = S_SHOW;
          presc_next_s = {PW{1'b0}};
        end else begin
          state_next_s = S_GUARD;
        end
      end
      S_SHOW: begin
        if (presc_r == SHOW_LAST) begin
          state_next_s = S_GUARD;
          presc_next_s = {PW{1'b0}};
          if (digit_r == DIGIT_LAST) begin
            digit_next_s = {DW{1'b0}};
            commit_s     = 1'b1;
          end else begin
            digit_next_s = digit_r + DW'(1);
          end
        end else begin
          state_next_s = S_SHOW;
        end
      end
      default: begin
        state_next_s = S_GUARD;
        digit_next_s = {DW{1'b0}};
        presc_next_s = {PW{1'b0}};
      end
    endcase
  end

  // Value latching: the commit reads the shadow before any same-cycle load
  // overwrites it, so a colliding load stays pending for the next frame.
  always_comb begin
    active_next_s  = active_r;
    shadow_next_s  = shadow_r;
    pending_next_s = pending_r;
    if (commit_s && pending_r) begin
      active_next_s = shadow_r;
    end else begin
      active_next_s = active_r;
    end
    if (load) begin
      shadow_next_s  = value_in;
      pending_next_s = 1'b1;
    end else if (commit_s) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Output decode for the coming cycle: nibble of the next digit, its enable
  // unless blanked as a leading zero, and the end-of-frame pulse.
  always_comb begin
    active_pad_s                   = {(4*MAX_DIGITS){1'b0}};
    active_pad_s[4*NUM_DIGITS-1:0] = active_next_s;
    lz_full_s                      = lz_mask(active_pad_s, NUM_DIGITS);
    digit_ext_s                    = 3'b000;
    digit_ext_s[DW-1:0]            = digit_next_s;
    suppress_s                     = blank_lz & lz_full_s[digit_ext_s];
    nibble_next_s                  = 4'h0;
    en_next_s                      = {NUM_DIGITS{1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_next_s == DW'(i)) begin
        nibble_next_s = active_next_s[4*i +: 4];
        if ((state_next_s == S_SHOW) && !suppress_s) begin
          en_next_s[i] = 1'b0;
        end else begin
          en_next_s[i] = 1'b1;
        end
      end else begin
        en_next_s[i] = 1'b1;
      end
    end
    if ((state_next_s == S_SHOW) && (digit_next_s == DIGIT_LAST) &&
        (presc_next_s == SHOW_LAST)) begin
      frame_done_next_s = 1'b1;
    end else begin
      frame_done_next_s = 1'b0;
    end
  end

  // State, value registers and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_GUARD;
      digit_r    <= {DW{1'b0}};
      presc_r    <= {PW{1'b0}};
      shadow_r   <= {(4*NUM_DIGITS){1'b0}};
      active_r   <= {(4*NUM_DIGITS){1'b0}};
      pending_r  <= 1'b0;
      nibble_out <= 4'h0;
      digit_en_n <= {NUM_DIGITS{1'b1}};
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      digit_r    <= digit_next_s;
      presc_r    <= presc_next_s;
      shadow_r   <= shadow_next_s;
      active_r   <= active_next_s;
      pending_r  <= pending_next_s;
      nibble_out <= nibble_next_s;
      digit_en_n <= en_next_s;
      frame_done <= frame_done_next_s;
    end
  end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed scan controller for the board's multi-digit seven-segment display in the MIPS debug path. It latches a packed hex value (PC, register or ALU result) tear-free at frame boundaries. It walks the digits one at a time, presenting each 4-bit nibble to the combinational seven-segment decoder and driving the matching active-low digit enable. A guard interval with all digits off precedes every digit to suppress ghosting, and optional leading-zero blanking is supported.

## Interface
- NUM_DIGITS, 4, number of digits scanned; 1..8
- REFRESH_DIV, 50000, clock cycles each digit is lit (SHOW length); ≥1
- GUARD_CYCLES, 16, clock cycles all digits are off before each digit (GUARD length); ≥1
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- value_in  in  4*NUM_DIGITS  packed hex value; nibble i = value_in[4i+3:4i], digit 0 is rightmost
- load  in  1  one-cycle strobe; captures value_in into the shadow register
- blank_lz  in  1  1 = suppress leading zero digits
- nibble_out  out  4  nibble for the downstream seven-segment decoder
- digit_en_n  out  NUM_DIGITS  active-low digit enables; at most one bit low
- frame_done  out  1  one-cycle pulse at end of last digit's SHOW

## Operation
- Registers: shadow and active (4*NUM_DIGITS each), pending flag, state {S_GUARD, S_SHOW}, digit index, prescaler.
- load=1: shadow <= value_in, pending <= 1. Back-to-back loads overwrite; only the last is kept.
- Commit happens on the final SHOW cycle of digit NUM_DIGITS-1. If pending is 1: active <= shadow, pending <= 0. frame_done pulses in the same cycle.
- Simultaneous load and commit: the commit takes the old shadow. The new value goes to shadow, pending stays 1, and it commits next frame.
- S_GUARD(i): digit_en_n all 1; nibble_out = active nibble i (committed value); lasts GUARD_CYCLES cycles, then S_SHOW(i).
- S_SHOW(i): nibble_out held; digit_en_n[i]=0 unless i is suppressed; lasts REFRESH_DIV cycles, then S_GUARD((i+1) mod NUM_DIGITS).
- Suppression: only when blank_lz=1, i>0, and active nibbles i..NUM_DIGITS-1 are all zero. A suppressed digit keeps its timing slot with digit_en_n all 1. Digit 0 is never suppressed, so value 0 shows a single "0".
- blank_lz is sampled every cycle; a change takes effect on the next cycle.
- Prescaler counts 0..len-1 within a state and clears on each transition.

## Timing
- Reset (rst_n=0 at an edge) sets: state S_GUARD, digit 0, prescaler 0, active=shadow=0, pending 0, nibble_out 0, digit_en_n all 1, frame_done 0.
- Reset mid-frame aborts the scan immediately, with the same values; a pending load is discarded.
- All outputs are registered and change only on clk edges.
- Digit 0 lights GUARD_CYCLES cycles after reset release.
- Frame length is NUM_DIGITS*(GUARD_CYCLES+REFRESH_DIV) cycles.
- Worst-case load-to-display latency is two frames plus GUARD_CYCLES.
- nibble_out changes only at S_GUARD entry, never while any digit is enabled.

## Structure
- Shared package display_pkg holds:
  - the state enum {S_GUARD, S_SHOW}
  - default constants DEF_REFRESH_DIV, DEF_GUARD_CYCLES
  - function lz_mask(value, n), returning the per-digit suppression bits
- No sub-module; the prescaler, state, digit index and latch logic live in one module.
- seven_segment_decoder is instantiated beside this block at the display top level, fed by nibble_out; it is not instantiated inside this block.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2 (frame = 24 cycles).
- Reset: hold rst_n=0 3 cycles, then release -> digit_en_n=4'b1111 for cycles 0–1. Cycles 2–5 give digit_en_n=4'b1110 and nibble_out=0. frame_done first pulses at cycle 23.
- Load/commit: load value_in=16'hA3C5 at cycle 5 -> unchanged display until the commit at cycle 23. Next frame shows nibble_out 5,C,3,A with digit_en_n 1110,1101,1011,0111, each for 4 cycles after 2 guard cycles.
- Collision: load 16'h1234, then load 16'hBEEF on the exact commit cycle -> 1234 shown for one frame, BEEF from the following frame.
- Leading zeros: active=16'h0070, blank_lz=1 -> only digits 0 and 1 enable (nibbles 0,7); digits 2–3 slots keep digit_en_n=1111. With active=0, only digit 0 shows 0.
- Abort: assert rst_n=0 during S_SHOW of digit 2 with pending=1 -> next cycle all enables high and nibble_out=0. After release, display shows 0000; the pending value is lost.
- Invariant: random load/blank_lz stimulus for 1000 cycles -> never more than one bit of digit_en_n low, and nibble_out never changes while any bit is low.
